// File: rtl/pp_pkg.sv
`default_nettype none
// pp_pkg -- shared state encoding, counter widths and parameter limits for pp_sbox_stream. (rev 1.0)
package pp_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_FAIL     = 2'd2
  } state_t;

  localparam int OVF_W        = 8;
  localparam int RC_W         = 8;
  localparam int IN_W_MIN     = 3;
  localparam int IN_W_MAX     = 8;
  localparam int DEPTH_MIN    = 2;
  localparam int DEPTH_MAX    = 16;
  localparam int RC_LIMIT_MIN = 2;
  localparam int RC_LIMIT_MAX = 255;

  function automatic bit in_range(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic bit is_pow2(int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pp_fifo.sv
`default_nettype none
// pp_fifo -- power-of-two synchronous FIFO; head word is presented combinationally on dout. (rev 1.0)
module pp_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pp_sbox_stream.sv
`default_nettype none
// pp_sbox_stream -- collects raw TRNG bits into words, XOR-compresses them and buffers the result.
// Define PP_HEALTH_TEST_EN to build the repetition-count health test. (rev 1.0)
module pp_sbox_stream
  import pp_pkg::*;
#(
  parameter int IN_W       = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int RC_LIMIT   = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          EN,
  input  logic                          BIT_IN,
  input  logic                          BIT_VLD,
  output logic [IN_W-2:0]               D_OUT,
  output logic                          OUT_VLD,
  input  logic                          OUT_RDY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LVL,
  output logic [OVF_W-1:0]              OVF_CNT,
  output logic                          HEALTH_FAIL,
  input  logic                          HEALTH_CLR
);

  if (!in_range(IN_W, IN_W_MIN, IN_W_MAX)) begin : g_bad_in_w
    $error("pp_sbox_stream: IN_W out of range");
  end
  if (!in_range(FIFO_DEPTH, DEPTH_MIN, DEPTH_MAX) || !is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("pp_sbox_stream: FIFO_DEPTH must be a power of 2 in range");
  end
  if (!in_range(RC_LIMIT, RC_LIMIT_MIN, RC_LIMIT_MAX)) begin : g_bad_rc_limit
    $error("pp_sbox_stream: RC_LIMIT out of range");
  end

  localparam int CW = $clog2(IN_W);
  localparam int WW = IN_W - 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IN_W - 1);

  state_t          state;
  state_t          state_nxt;
  logic            collecting;
  logic            accept;
  logic            last_bit;
  logic            health_hit;
  logic            health_clr;
  logic            push_req;
  logic            pop;
  logic            drop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   bit_cnt;
  logic [WW-1:0]   w;
  logic [IN_W-1:0] word_full;
  logic [WW-1:0]   word_cmp;

  assign accept    = collecting && EN && BIT_VLD;
  assign last_bit  = (bit_cnt == LAST_IDX);
  assign push_req  = accept && last_bit && !health_hit;
  assign pop       = OUT_VLD && OUT_RDY;
  assign drop      = push_req && fifo_full && !pop;
  assign OUT_VLD   = !fifo_empty;

  // The final bit is never stored; it joins the word straight from the input.
  assign word_full = {BIT_IN, w};
  assign word_cmp  = word_full[WW-1:0] ^ word_full[IN_W-1:1];

`ifdef PP_HEALTH_TEST_EN
  logic [RC_W-1:0] run_cnt;
  logic [RC_W-1:0] run_nxt;
  logic            prev_bit;

  assign run_nxt    = ((run_cnt != '0) && (BIT_IN == prev_bit)) ? run_cnt + RC_W'(1) : RC_W'(1);
  assign health_hit = accept && (run_nxt == RC_W'(RC_LIMIT));
  assign health_clr = (state == ST_FAIL) && HEALTH_CLR;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_cnt  <= '0;
      prev_bit <= 1'b0;
    end else if (health_clr) begin
      run_cnt  <= '0;
    end else if (accept) begin
      run_cnt  <= run_nxt;
      prev_bit <= BIT_IN;
    end
  end
`else
  logic unused_health_clr;
  assign unused_health_clr = HEALTH_CLR;
  assign health_hit        = 1'b0;
  assign health_clr        = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_DISABLED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DISABLED: if (EN) state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        if (!EN)             state_nxt = ST_DISABLED;
        else if (health_hit) state_nxt = ST_FAIL;
      end
      ST_FAIL:     if (health_clr) state_nxt = EN ? ST_COLLECT : ST_DISABLED;
      default:     state_nxt = ST_DISABLED;
    endcase
  end

  always_comb begin
    collecting  = (state == ST_COLLECT);
`ifdef PP_HEALTH_TEST_EN
    HEALTH_FAIL = (state == ST_FAIL);
`else
    HEALTH_FAIL = 1'b0;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt <= '0;
      w       <= '0;
      OVF_CNT <= '0;
    end else begin
      if ((collecting && !EN) || health_hit || health_clr || (accept && last_bit)) begin
        bit_cnt <= '0;
        w       <= '0;
      end else if (accept) begin
        bit_cnt <= bit_cnt + CW'(1);
        for (int i = 0; i < WW; i++) begin
          if (bit_cnt == CW'(i)) w[i] <= BIT_IN;
        end
      end
      if (drop && (OVF_CNT != '1)) OVF_CNT <= OVF_CNT + OVF_W'(1);
    end
  end

  pp_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push_req),
    .pop   (pop),
    .din   (word_cmp),
    .dout  (D_OUT),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (FIFO_LVL)
  );

endmodule
`default_nettype wire

// File: tb/tb_pp_sbox_stream.sv
`default_nettype none
// tb_pp_sbox_stream -- directed vectors checked against a queue-based reference model. (rev 1.0)
module tb_pp_sbox_stream;

  localparam int IN_W       = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int RC_LIMIT   = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef PP_HEALTH_TEST_EN
  localparam bit HEALTH_ON  = 1'b1;
`else
  localparam bit HEALTH_ON  = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic EN = 1'b0;
  logic BIT_IN = 1'b0;
  logic BIT_VLD = 1'b0;
  logic OUT_RDY = 1'b0;
  logic HEALTH_CLR = 1'b0;
  logic [IN_W-2:0] D_OUT;
  logic            OUT_VLD;
  logic [LW-1:0]   FIFO_LVL;
  logic [7:0]      OVF_CNT;
  logic            HEALTH_FAIL;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  pp_sbox_stream #(
    .IN_W       (IN_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RC_LIMIT   (RC_LIMIT)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .EN          (EN),
    .BIT_IN      (BIT_IN),
    .BIT_VLD     (BIT_VLD),
    .D_OUT       (D_OUT),
    .OUT_VLD     (OUT_VLD),
    .OUT_RDY     (OUT_RDY),
    .FIFO_LVL    (FIFO_LVL),
    .OVF_CNT     (OVF_CNT),
    .HEALTH_FAIL (HEALTH_FAIL),
    .HEALTH_CLR  (HEALTH_CLR)
  );

  always #5 CLK = ~CLK;

  function automatic void check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Reference model: 0 = disabled, 1 = collecting, 2 = failed.
  int              m_state = 0;
  bit              m_bits[$];
  logic [IN_W-2:0] m_fifo[$];
  int              m_ovf = 0;
  int              m_run = 0;
  bit              m_prev = 1'b0;
  bit              mdl_pop;
  bit              mdl_have;
  int              mdl_lvl;
  logic [IN_W-2:0] mdl_word;

  function automatic logic [IN_W-2:0] compress_bits();
    logic [IN_W-1:0] v;
    logic [IN_W-2:0] d;
    for (int i = 0; i < IN_W; i++) v[i] = m_bits[i];
    for (int j = 0; j < IN_W - 1; j++) d[j] = v[j] ^ v[j+1];
    return d;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_state = 0;
      m_bits.delete();
      m_fifo.delete();
      m_ovf  = 0;
      m_run  = 0;
      m_prev = 1'b0;
    end else begin
      mdl_lvl  = m_fifo.size();
      mdl_pop  = (mdl_lvl > 0) && OUT_RDY;
      mdl_have = 1'b0;
      mdl_word = '0;
      case (m_state)
        0: if (EN) m_state = 1;
        1: begin
          if (!EN) begin
            m_state = 0;
            m_bits.delete();
          end else if (BIT_VLD) begin
            m_run  = (m_run > 0 && BIT_IN == m_prev) ? m_run + 1 : 1;
            m_prev = BIT_IN;
            if (HEALTH_ON && m_run == RC_LIMIT) begin
              m_state = 2;
              m_bits.delete();
            end else begin
              m_bits.push_back(BIT_IN);
              if (m_bits.size() == IN_W) begin
                mdl_word = compress_bits();
                mdl_have = 1'b1;
                m_bits.delete();
              end
            end
          end
        end
        default: if (HEALTH_CLR) begin
          m_run = 0;
          m_bits.delete();
          m_state = EN ? 1 : 0;
        end
      endcase
      if (mdl_pop) void'(m_fifo.pop_front());
      if (mdl_have) begin
        if (mdl_lvl == FIFO_DEPTH && !mdl_pop) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          m_fifo.push_back(mdl_word);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N && cmp_en) begin
      check("model_out_vld", OUT_VLD, m_fifo.size() > 0);
      if (m_fifo.size() > 0) check("model_d_out", D_OUT, m_fifo[0]);
      check("model_fifo_lvl", FIFO_LVL, m_fifo.size());
      check("model_ovf_cnt", OVF_CNT, m_ovf);
      check("model_health_fail", HEALTH_FAIL, m_state == 2);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    BIT_IN  = b;
    BIT_VLD = 1'b1;
    tick();
    BIT_VLD = 1'b0;
  endtask

  // v[0] is sent first.
  task automatic send_word(input logic [IN_W-1:0] v);
    for (int i = 0; i < IN_W; i++) send_bit(v[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    check("rst_out_vld", OUT_VLD, 0);
    check("rst_d_out", D_OUT, 0);
    check("rst_fifo_lvl", FIFO_LVL, 0);
    check("rst_ovf_cnt", OVF_CNT, 0);
    check("rst_health_fail", HEALTH_FAIL, 0);
    RST_N  = 1'b1;
    cmp_en = 1'b1;

    EN = 1'b1;
    tick();
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    BIT_IN = 1'b0; BIT_VLD = 1'b1; #1;
    check("no_bypass_vld", OUT_VLD, 0);
    tick();
    BIT_VLD = 1'b0;
    check("cmp_out_vld", OUT_VLD, 1);
    check("cmp_d_out", D_OUT, 4'b1011);
    OUT_RDY = 1'b1; tick(); OUT_RDY = 1'b0;
    check("drain1_lvl", FIFO_LVL, 0);

    send_word(5'b01011); send_word(5'b10010); send_word(5'b00111);
    send_word(5'b11001); send_word(5'b01110); send_word(5'b10101);
    check("ovf_lvl", FIFO_LVL, 4);
    check("ovf_cnt", OVF_CNT, 2);
    check("ovf_head", D_OUT, 4'b1110);

    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    OUT_RDY = 1'b1;
    send_bit(1);
    OUT_RDY = 1'b0;
    check("fullpop_lvl", FIFO_LVL, 4);
    check("fullpop_ovf", OVF_CNT, 2);
    check("fullpop_head", D_OUT, 4'b1011);
    OUT_RDY = 1'b1; repeat (4) tick(); OUT_RDY = 1'b0;
    check("drain2_lvl", FIFO_LVL, 0);

    send_bit(1); send_bit(1); send_bit(1);
    EN = 1'b0; tick();
    EN = 1'b1; BIT_IN = 1'b1; BIT_VLD = 1'b1; tick(); BIT_VLD = 1'b0;
    send_word(5'b00110);
    check("dis_lvl", FIFO_LVL, 1);
    check("dis_word", D_OUT, 4'b0101);
    OUT_RDY = 1'b1; tick();

    for (int i = 0; i < 16; i++) send_bit(1);
`ifdef PP_HEALTH_TEST_EN
    check("hlth_fail_set", HEALTH_FAIL, 1);
    for (int i = 0; i < 5; i++) send_bit(0);
    check("hlth_no_write_lvl", FIFO_LVL, 0);
    check("hlth_no_write_vld", OUT_VLD, 0);
    HEALTH_CLR = 1'b1; tick(); HEALTH_CLR = 1'b0;
    check("hlth_fail_clr", HEALTH_FAIL, 0);
`else
    check("hlth_tied_low", HEALTH_FAIL, 0);
    HEALTH_CLR = 1'b1; tick(); HEALTH_CLR = 1'b0;
    check("hlth_clr_ignored", HEALTH_FAIL, 0);
`endif
    EN = 1'b0; tick(); EN = 1'b1; tick();
    OUT_RDY = 1'b0;
    send_word(5'b01101);
    check("resume_lvl", FIFO_LVL, 1);
    check("resume_word", D_OUT, 4'b1011);

    OUT_RDY = 1'b1; tick(); OUT_RDY = 1'b0;
    send_word(5'b01011); send_word(5'b10010); send_word(5'b00111);
    check("pre_rst_lvl", FIFO_LVL, 3);
    check("pre_rst_vld", OUT_VLD, 1);
    send_bit(1); send_bit(1);
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_out_vld", OUT_VLD, 0);
    check("async_rst_d_out", D_OUT, 0);
    check("async_rst_lvl", FIFO_LVL, 0);
    check("async_rst_ovf", OVF_CNT, 0);
    check("async_rst_health", HEALTH_FAIL, 0);
    tick();
    RST_N = 1'b1;
    tick();
    send_word(5'b11001);
    check("post_rst_lvl", FIFO_LVL, 1);
    check("post_rst_word", D_OUT, 4'b0101);
    check("post_rst_ovf", OVF_CNT, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
